// File: rtl/bricks_pkg.sv
// Shared definitions for the paddle controller slice: display control codes,
// FSM state encoding and the paddle position width.
package bricks_pkg;

    localparam int PADDLE_W = 3;

    localparam logic [3:0] CTRL_STOP = 4'b1111;
    localparam logic [3:0] CTRL_R1   = 4'b0001;
    localparam logic [3:0] CTRL_R2   = 4'b0011;
    localparam logic [3:0] CTRL_L1   = 4'b0100;
    localparam logic [3:0] CTRL_L2   = 4'b0110;
    localparam logic [3:0] CTRL_IDLE = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1,
        ST_L2,
        ST_R1,
        ST_R2,
        ST_STOP
    } paddle_state_t;

    // Display code for a given FSM state.
    function automatic logic [3:0] ctrl_code(paddle_state_t s);
        case (s)
            ST_L1:   return CTRL_L1;
            ST_L2:   return CTRL_L2;
            ST_R1:   return CTRL_R1;
            ST_R2:   return CTRL_R2;
            ST_STOP: return CTRL_STOP;
            default: return CTRL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Button / display bundle of the paddle controller.
//   btn_left, btn_right, btn_pause : raw active-high buttons (master -> slave)
//   control    : 4-bit display code                  (slave -> master)
//   paddle_pos : leftmost paddle column              (slave -> master)
//   move_pulse : strobe in the cycle paddle_pos moves (slave -> master)
interface paddle_ctrl_if;
    import bricks_pkg::*;

    logic                btn_left;
    logic                btn_right;
    logic                btn_pause;
    logic [3:0]          control;
    logic [PADDLE_W-1:0] paddle_pos;
    logic                move_pulse;

    modport master (
        output btn_left, btn_right, btn_pause,
        input  control, paddle_pos, move_pulse
    );

    modport slave (
        input  btn_left, btn_right, btn_pause,
        output control, paddle_pos, move_pulse
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a debouncer.
//   clock, reset : system clock, synchronous active-high reset
//   din          : raw asynchronous input
//   dout         : debounced level, changes after DEBOUNCE_CYCLES equal samples
//   rise         : one-cycle pulse in the first cycle dout is high
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            // cnt tracks consecutive samples that disagree with dout;
            // any agreeing sample restarts it.
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                dout <= sync2;
                rise <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: debounces left/right/pause buttons, runs the direction /
// speed FSM and steps the paddle position.
//   clock, reset : 10 kHz clock, synchronous active-high reset
//   bus          : paddle_ctrl_if.slave (buttons in; control, paddle_pos,
//                  move_pulse out)
// Build option PADDLE_PAUSE_TOGGLE_EN: pause button toggles a paused flag on
// each debounced press instead of acting as a hold-to-stop level.
module paddle_ctrl
    import bricks_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int HOLD_CYCLES     = 5000,
    parameter int MOVE_CYCLES     = 2000,
    parameter int PADDLE_MAX      = 5
) (
    input  logic          clock,
    input  logic          reset,
    paddle_ctrl_if.slave  bus
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int MW = $clog2(MOVE_CYCLES);
    localparam logic [HW-1:0]       HOLD_MAX      = HW'(HOLD_CYCLES - 1);
    localparam logic [MW-1:0]       MOVE_MAX      = MW'(MOVE_CYCLES - 1);
    localparam logic [MW-1:0]       MOVE_HALF_MAX = MW'(MOVE_CYCLES / 2 - 1);
    localparam logic [PADDLE_W-1:0] POS_MAX       = PADDLE_W'(PADDLE_MAX);
    localparam logic [PADDLE_W-1:0] POS_RST       = PADDLE_W'((PADDLE_MAX + 1) / 2);

    logic db_l, db_r, db_p;
    logic rise_l, rise_r, rise_p;
    logic paused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clock(clock), .reset(reset), .din(bus.btn_left),  .dout(db_l), .rise(rise_l));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clock(clock), .reset(reset), .din(bus.btn_right), .dout(db_r), .rise(rise_r));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clock(clock), .reset(reset), .din(bus.btn_pause), .dout(db_p), .rise(rise_p));

`ifdef PADDLE_PAUSE_TOGGLE_EN
    logic pause_flag;
    logic unused_ok;
    assign unused_ok = &{1'b0, rise_l, rise_r, db_p};

    always_ff @(posedge clock) begin
        if (reset)       pause_flag <= 1'b0;
        else if (rise_p) pause_flag <= ~pause_flag;
    end
    // Folding the rise pulse in makes the toggle take effect in the same
    // cycle as a level change would, so both builds share one latency.
    assign paused = pause_flag ^ rise_p;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, rise_l, rise_r, rise_p};
    assign paused = db_p;
`endif

    paddle_state_t       state_q, next_state;
    logic [3:0]          control_q;
    logic [HW-1:0]       hold_cnt;
    logic [MW-1:0]       move_cnt;
    logic [PADDLE_W-1:0] pos_q;
    logic                pulse_q;

    logic          is_left, is_right, is_slow, moving, step, can_move;
    logic [MW-1:0] wrap;

    always_comb begin
        next_state = state_q;
        if (paused)              next_state = ST_STOP;
        else if (db_l && db_r)   next_state = ST_IDLE;
        else if (db_l)           next_state = ((state_q == ST_L1 && hold_cnt == HOLD_MAX) ||
                                               state_q == ST_L2) ? ST_L2 : ST_L1;
        else if (db_r)           next_state = ((state_q == ST_R1 && hold_cnt == HOLD_MAX) ||
                                               state_q == ST_R2) ? ST_R2 : ST_R1;
        else                     next_state = ST_IDLE;

        is_left  = (state_q == ST_L1) || (state_q == ST_L2);
        is_right = (state_q == ST_R1) || (state_q == ST_R2);
        is_slow  = (state_q == ST_L1) || (state_q == ST_R1);
        // Motion only accumulates while the direction state is stable; any
        // state change restarts the step period.
        moving   = (is_left || is_right) && (next_state == state_q);
        wrap     = is_slow ? MOVE_MAX : MOVE_HALF_MAX;
        step     = moving && (move_cnt == wrap);
        can_move = is_left ? (pos_q != '0) : (pos_q != POS_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            control_q <= CTRL_IDLE;
            hold_cnt  <= '0;
            move_cnt  <= '0;
            pos_q     <= POS_RST;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= next_state;
            control_q <= ctrl_code(next_state);

            if (next_state != state_q || !is_slow) hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)         hold_cnt <= hold_cnt + 1'b1;

            if (!moving || step) move_cnt <= '0;
            else                 move_cnt <= move_cnt + 1'b1;

            pulse_q <= step && can_move;
            if (step && can_move)
                pos_q <= is_left ? pos_q - 1'b1 : pos_q + 1'b1;
        end
    end

    assign bus.control    = control_q;
    assign bus.paddle_pos = pos_q;
    assign bus.move_pulse = pulse_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
module tb_paddle_ctrl;
    import bricks_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [3:0] ctrl;
        logic [2:0] pos;
        int         at;
    } exp_t;
    exp_t expq[$];

    paddle_ctrl_if pif();

    paddle_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (pif.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        rst_q <= reset;
    end

    // Monitor: every visible change of {control, paddle_pos} must match the
    // next scoreboard entry, including the cycle it occurs in.
    logic [3:0] prev_c;
    logic [2:0] prev_p;
    always @(negedge clock) begin
        exp_t e;
        if (rst_q) begin
            prev_c = pif.control;
            prev_p = pif.paddle_pos;
        end else begin
            if (pif.move_pulse || pif.paddle_pos !== prev_p) begin
                checks++;
                if (pif.move_pulse !== (pif.paddle_pos !== prev_p)) begin
                    errors++;
                    $display("FAIL move_pulse cyc=%0d pulse=%b pos %0d->%0d", cyc,
                             pif.move_pulse, prev_p, pif.paddle_pos);
                end
            end
            if (pif.control !== prev_c || pif.paddle_pos !== prev_p) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d control=%b pos=%0d", cyc,
                             pif.control, pif.paddle_pos);
                end else begin
                    e = expq.pop_front();
                    if (e.ctrl !== pif.control || e.pos !== pif.paddle_pos || e.at != cyc) begin
                        errors++;
                        $display("FAIL event cyc=%0d control=%b pos=%0d expected cyc=%0d control=%b pos=%0d",
                                 cyc, pif.control, pif.paddle_pos, e.at, e.ctrl, e.pos);
                    end
                end
            end
            prev_c = pif.control;
            prev_p = pif.paddle_pos;
        end
    end

    task automatic push(input logic [3:0] c, input logic [2:0] p, input int at);
        exp_t e;
        e.ctrl = c; e.pos = p; e.at = at;
        expq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic step_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    int t_ref;

    task automatic test_reset;
        reset = 1'b1;
        pif.btn_left = 1'b0; pif.btn_right = 1'b0; pif.btn_pause = 1'b0;
        step(3);
        checks++; if (pif.control !== CTRL_IDLE) begin errors++; $display("FAIL reset_control got=%b exp=%b", pif.control, CTRL_IDLE); end
        checks++; if (pif.paddle_pos !== 3'd3) begin errors++; $display("FAIL reset_pos got=%0d exp=3", pif.paddle_pos); end
        checks++; if (pif.move_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", pif.move_pulse); end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_short_press;
        pif.btn_right = 1'b1;
        step(150);
        checks++; if (pif.control !== CTRL_IDLE) begin errors++; $display("FAIL short_control got=%b exp=%b", pif.control, CTRL_IDLE); end
        pif.btn_right = 1'b0;
        step(250);
        checks++; if (pif.control !== CTRL_IDLE || pif.paddle_pos !== 3'd3) begin
            errors++; $display("FAIL short_after got=%b/%0d exp=%b/3", pif.control, pif.paddle_pos, CTRL_IDLE);
        end
    endtask

    task automatic test_right;
        t_ref = cyc;
        pif.btn_right = 1'b1;
        push(CTRL_R1, 3'd3, t_ref + 203);
        push(CTRL_R1, 3'd4, t_ref + 2203);
        step_to(t_ref + 3000);
        checks++; if (pif.control !== CTRL_R1 || pif.paddle_pos !== 3'd4) begin
            errors++; $display("FAIL right_hold got=%b/%0d exp=%b/4", pif.control, pif.paddle_pos, CTRL_R1);
        end
    endtask

    task automatic test_escalate;
        push(CTRL_R1, 3'd5, t_ref + 4203);
        push(CTRL_R2, 3'd5, t_ref + 5203);
        step_to(t_ref + 6500);
        checks++; if (pif.control !== CTRL_R2 || pif.paddle_pos !== 3'd5) begin
            errors++; $display("FAIL escalate got=%b/%0d exp=%b/5", pif.control, pif.paddle_pos, CTRL_R2);
        end
    endtask

    task automatic test_pause;
        int c;
        c = cyc;
        pif.btn_pause = 1'b1;
        push(CTRL_STOP, 3'd5, c + 203);
        step(400);
        checks++; if (pif.control !== CTRL_STOP) begin errors++; $display("FAIL pause_stop got=%b exp=%b", pif.control, CTRL_STOP); end
        pif.btn_pause = 1'b0;
`ifdef PADDLE_PAUSE_TOGGLE_EN
        step(400);
        checks++; if (pif.control !== CTRL_STOP) begin errors++; $display("FAIL pause_release got=%b exp=%b", pif.control, CTRL_STOP); end
        c = cyc;
        pif.btn_pause = 1'b1;
        push(CTRL_R1, 3'd5, c + 203);
        step(400);
        pif.btn_pause = 1'b0;
`else
        c = cyc;
        push(CTRL_R1, 3'd5, c + 203);
        step(400);
`endif
        checks++; if (pif.control !== CTRL_R1) begin errors++; $display("FAIL pause_leave got=%b exp=%b", pif.control, CTRL_R1); end
        c = cyc;
        pif.btn_right = 1'b0;
        push(CTRL_IDLE, 3'd5, c + 203);
        step(300);
        checks++; if (pif.control !== CTRL_IDLE) begin errors++; $display("FAIL right_release got=%b exp=%b", pif.control, CTRL_IDLE); end
    endtask

    task automatic test_both_in_l2;
        int c;
        c = cyc;
        pif.btn_left = 1'b1;
        push(CTRL_L1, 3'd5, c + 203);
        push(CTRL_L1, 3'd4, c + 2203);
        push(CTRL_L1, 3'd3, c + 4203);
        push(CTRL_L2, 3'd3, c + 5203);
        step_to(c + 5500);
        checks++; if (pif.control !== CTRL_L2 || pif.paddle_pos !== 3'd3) begin
            errors++; $display("FAIL left_l2 got=%b/%0d exp=%b/3", pif.control, pif.paddle_pos, CTRL_L2);
        end
        pif.btn_right = 1'b1;
        push(CTRL_IDLE, 3'd3, c + 5703);
        step_to(c + 5710);
        checks++; if (pif.control !== CTRL_IDLE) begin errors++; $display("FAIL both_idle got=%b exp=%b", pif.control, CTRL_IDLE); end
        step_to(c + 6000);
        pif.btn_right = 1'b0;
        // hold_cnt must have been cleared: full L1 period before L2 again.
        push(CTRL_L1, 3'd3, c + 6203);
        push(CTRL_L1, 3'd2, c + 8203);
        push(CTRL_L1, 3'd1, c + 10203);
        step_to(c + 11100);
        checks++; if (pif.control !== CTRL_L1) begin errors++; $display("FAIL hold_cleared got=%b exp=%b", pif.control, CTRL_L1); end
        push(CTRL_L2, 3'd1, c + 11203);
        push(CTRL_L2, 3'd0, c + 12203);
        step_to(c + 12500);
        checks++; if (pif.control !== CTRL_L2 || pif.paddle_pos !== 3'd0) begin
            errors++; $display("FAIL left_sat got=%b/%0d exp=%b/0", pif.control, pif.paddle_pos, CTRL_L2);
        end
    endtask

    task automatic test_reset_mid;
        int d, e;
        d = cyc;
        pif.btn_left = 1'b0;
        push(CTRL_IDLE, 3'd0, d + 203);
        step(400);
        e = cyc;
        pif.btn_left = 1'b1;
        push(CTRL_L1, 3'd0, e + 203);
        step_to(e + 1703);
        reset = 1'b1;
        step(1);
        checks++; if (pif.control !== CTRL_IDLE) begin errors++; $display("FAIL mid_reset_control got=%b exp=%b", pif.control, CTRL_IDLE); end
        checks++; if (pif.paddle_pos !== 3'd3) begin errors++; $display("FAIL mid_reset_pos got=%0d exp=3", pif.paddle_pos); end
        checks++; if (pif.move_pulse !== 1'b0) begin errors++; $display("FAIL mid_reset_pulse got=%b exp=0", pif.move_pulse); end
        reset = 1'b0;
        d = cyc;
        // Left stays held: debouncer and move counter start from scratch.
        push(CTRL_L1, 3'd3, d + 203);
        push(CTRL_L1, 3'd2, d + 2203);
        step_to(d + 2300);
        checks++; if (pif.control !== CTRL_L1 || pif.paddle_pos !== 3'd2) begin
            errors++; $display("FAIL after_reset got=%b/%0d exp=%b/2", pif.control, pif.paddle_pos, CTRL_L1);
        end
    endtask

    initial begin
        pif.btn_left = 1'b0; pif.btn_right = 1'b0; pif.btn_pause = 1'b0;
        test_reset();
        test_short_press();
        test_right();
        test_escalate();
        test_pause();
        test_both_in_l2();
        test_reset_mid();
        step(2);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d exp=0 next_at=%0d", expq.size(), expq[0].at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
